// File: rtl/reorder_pingpong_pkg.sv
// Shared definitions for the ping-pong bit-reversal reorder buffer:
// bank state encoding and a generic N-bit bit-reversal helper.
package reorder_pingpong_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Widest index the bit-reverse helper handles; frame counters are
  // zero-extended to this width before reversal.
  localparam int BITREV_W = 32;

  // Reverse the low n bits of v; bits at and above n come back as zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v,
                                                 input int n);
    logic [BITREV_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_W; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_pingpong_sdp_ram_en.sv
// Simple dual-port RAM: synchronous write port, registered read port whose
// output register only loads when rd_en is high (data holds otherwise).
module sdp_ram_en #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port with enable.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/reorder_pingpong.sv
// Ping-pong reorder buffer behind the radix-2 FFT. One bank fills in write
// order while the other drains, either bit-reversed (natural FFT order) or
// straight through, as selected per frame by mode_bitrev at index 0.
module reorder_pingpong #(
  parameter int WIDTH = 16,
  parameter int N     = 9
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    mode_bitrev,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_idx,
  output logic                    out_last,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  import reorder_pingpong_pkg::*;

  localparam logic [N-1:0] CNT_MAX = '1;

  bank_state_t            bank_st     [2];
  bank_state_t            bank_st_nxt [2];
  logic [1:0]             bank_mode;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [N-1:0]           wr_cnt;
  logic [N-1:0]           rd_cnt;
  logic                   wr_en;
  logic                   rd_avail;
  logic                   rd_en;
  logic [BITREV_W-1:0]    rd_cnt_rev;
  logic [N-1:0]           rd_ofs_p0;
  logic [2*WIDTH-1:0]     rd_word_p1;

  // Stage p0: handshake decode and read address generation.
  assign in_ready   = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
  assign wr_en      = in_valid && in_ready;
  assign rd_avail   = (bank_st[rd_bank] == BANK_FULL) || (bank_st[rd_bank] == BANK_DRAINING);
  assign rd_en      = rd_avail && (!out_valid || out_ready);
  assign rd_cnt_rev = bitrev(BITREV_W'(rd_cnt), N);
  assign rd_ofs_p0  = bank_mode[rd_bank] ? rd_cnt_rev[N-1:0] : rd_cnt;

  // Bank state next-state: writes and reads never target the same bank in
  // one cycle, since a bank is writable only when EMPTY/FILLING and readable
  // only when FULL/DRAINING.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_nxt[b] = bank_st[b];
      if (wr_en && (wr_bank == 1'(b)))
        bank_st_nxt[b] = (wr_cnt == CNT_MAX) ? BANK_FULL : BANK_FILLING;
      if (rd_en && (rd_bank == 1'(b)))
        bank_st_nxt[b] = (rd_cnt == CNT_MAX) ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
    end
  end

  // Write side: counter, bank toggle and per-bank mode latch at index 0.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_mode <= 2'b11;
    end else if (wr_en) begin
      if (wr_cnt == '0) bank_mode[wr_bank] <= mode_bitrev;
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == CNT_MAX) wr_bank <= ~wr_bank;
    end
  end

  // Stage p1: read counter, output valid and index/last registered in step
  // with the RAM read so they stay aligned with the sample.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (rd_en) begin
      rd_cnt    <= rd_cnt + 1'b1;
      if (rd_cnt == CNT_MAX) rd_bank <= ~rd_bank;
      out_valid <= 1'b1;
      out_idx   <= rd_cnt;
      out_last  <= (rd_cnt == CNT_MAX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  sdp_ram_en #(
    .DW(2*WIDTH),
    .AW(N+1)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wr_bank, wr_cnt}),
    .wr_data({in_re, in_im}),
    .rd_en  (rd_en),
    .rd_addr({rd_bank, rd_ofs_p0}),
    .rd_data(rd_word_p1)
  );

  assign out_re = $signed(rd_word_p1[2*WIDTH-1:WIDTH]);
  assign out_im = $signed(rd_word_p1[WIDTH-1:0]);

endmodule

// File: tb/tb_reorder_pingpong.sv
// Scoreboard bench for reorder_pingpong (WIDTH=16, N=3). The input monitor
// collects accepted samples into whole frames and queues the expected output
// sequence; the output monitor pops and compares on every output handshake.
module tb_reorder_pingpong;

  localparam int W     = 16;
  localparam int LOGN  = 3;
  localparam int FRAME = 1 << LOGN;

  logic                clk = 1'b0;
  logic                areset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                mode_bitrev;
  logic                out_valid;
  logic                out_ready;
  logic [LOGN-1:0]     out_idx;
  logic                out_last;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  typedef struct packed {
    logic [LOGN-1:0]     idx;
    logic                last;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   stall_cnt = 0;
  int   pop_cnt   = 0;
  int   run_len   = 0;
  int   last_pop  = -10;
  int   cyc       = 0;
  logic wdone;

  reorder_pingpong #(.WIDTH(W), .N(LOGN)) dut (
    .clk        (clk),
    .areset     (areset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .mode_bitrev(mode_bitrev),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_re     (out_re),
    .out_im     (out_im)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit reversal of a frame position, by plain arithmetic.
  function automatic int rev(input int j);
    int r = 0;
    for (int k = 0; k < LOGN; k++)
      if (((j >> k) & 1) == 1) r += 1 << (LOGN - 1 - k);
    return r;
  endfunction

  // Input side model: frames are collected and, once complete, their
  // expected output sequence is queued.
  logic signed [W-1:0] fr_re [FRAME];
  logic signed [W-1:0] fr_im [FRAME];
  int                  in_cnt = 0;
  logic                fr_mode = 1'b1;

  always @(negedge clk) begin
    if (!areset) begin
      in_cnt = 0;
    end else if (in_valid && in_ready) begin
      if (in_cnt == 0) fr_mode = mode_bitrev;
      fr_re[in_cnt] = in_re;
      fr_im[in_cnt] = in_im;
      in_cnt++;
      if (in_cnt == FRAME) begin
        for (int j = 0; j < FRAME; j++) begin
          exp_t e;
          int   src;
          src    = fr_mode ? rev(j) : j;
          e.idx  = LOGN'(j);
          e.last = (j == FRAME - 1);
          e.re   = fr_re[src];
          e.im   = fr_im[src];
          exp_q.push_back(e);
        end
        in_cnt = 0;
      end
    end
  end

  // Output monitor: compare on handshake, check hold during stalls.
  logic                held_vld = 1'b0;
  logic [LOGN-1:0]     h_idx;
  logic                h_last;
  logic signed [W-1:0] h_re;
  logic signed [W-1:0] h_im;

  always @(negedge clk) begin
    if (!areset) begin
      exp_q.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        checks++;
        if (!out_valid || out_idx !== h_idx || out_last !== h_last ||
            out_re !== h_re || out_im !== h_im) begin
          failures++;
          $display("FAIL stall_hold got vld=%0b idx=%0d last=%0b re=%0d im=%0d expected vld=1 idx=%0d last=%0b re=%0d im=%0d",
                   out_valid, out_idx, out_last, out_re, out_im, h_idx, h_last, h_re, h_im);
        end
      end
      held_vld = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected got idx=%0d re=%0d expected no output", out_idx, out_re);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_idx !== e.idx || out_last !== e.last || out_re !== e.re || out_im !== e.im) begin
              failures++;
              $display("FAIL out_sample got idx=%0d last=%0b re=%0d im=%0d expected idx=%0d last=%0b re=%0d im=%0d",
                       out_idx, out_last, out_re, out_im, e.idx, e.last, e.re, e.im);
            end
          end
          pop_cnt++;
          if (cyc == last_pop + 1) run_len++;
          else run_len = 1;
          last_pop = cyc;
        end else begin
          held_vld = 1'b1;
          h_idx    = out_idx;
          h_last   = out_last;
          h_re     = out_re;
          h_im     = out_im;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input logic m);
    int n;
    n           = 0;
    in_valid    = 1'b1;
    in_re       = re;
    in_im       = im;
    mode_bitrev = m;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got in_ready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    idle(3);
  endtask

  initial begin
    int p0;
    areset      = 1'b0;
    in_valid    = 1'b0;
    in_re       = '0;
    in_im       = '0;
    mode_bitrev = 1'b1;
    out_ready   = 1'b1;
    wdone       = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    tick();
    areset = 1'b1;
    tick();

    // Single bit-reversed frame, latency of the first output.
    for (int i = 0; i < FRAME; i++) send(W'(i), W'($urandom), 1'b1);
    in_valid = 1'b0;
    chk("lat_before", out_valid, 0);
    tick();
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_idx", out_idx, 0);
    wait_drain();

    // Three back-to-back frames, modes 1,0,1: no input stall, no output gap.
    stall_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FRAME; i++)
        send(W'($urandom), W'($urandom), (f == 1) ? 1'b0 : 1'b1);
    in_valid = 1'b0;
    chk("t2_in_stalls", stall_cnt, 0);
    wait_drain();
    chk("t2_out_run", run_len, 3 * FRAME);

    // Backpressure at output index 3 while input keeps streaming.
    p0 = pop_cnt;
    fork
      begin
        for (int k = 0; k < 3 * FRAME; k++) send(W'(k), W'($urandom), 1'b1);
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!(out_valid && out_idx == 3) && n < 100) begin
          tick();
          n++;
        end
        chk("t3_reach_idx3", out_idx, 3);
        out_ready = 1'b0;
        for (int s = 0; s < 12; s++) begin
          tick();
          chk("t3_stall_re", out_re, 6);
        end
        chk("t3_both_full", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t3_count", pop_cnt - p0, 3 * FRAME);

    // Mode changed mid-frame: only index 0 counts.
    for (int i = 0; i < FRAME; i++) send(W'($urandom), W'($urandom), (i < 4) ? 1'b1 : 1'b0);
    for (int i = 0; i < FRAME; i++) send(W'($urandom), W'($urandom), (i < 4) ? 1'b0 : 1'b1);
    wait_drain();

    // Reset during drain at out_idx=5 with a partial frame behind it.
    for (int i = 0; i < FRAME; i++) send(W'(100 + i), W'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) send(W'(200 + i), W'($urandom), 1'b0);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!(out_valid && out_idx == 5) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reach_idx5", out_idx, 5);
    end
    #2;
    areset = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_out_idx", out_idx, 0);
    tick();
    tick();
    areset = 1'b1;
    tick();
    p0 = pop_cnt;
    for (int i = 0; i < FRAME; i++) send(W'($urandom), W'($urandom), 1'b1);
    wait_drain();
    chk("t5_count", pop_cnt - p0, FRAME);

    // Alternating input gaps on a bit-reversed frame.
    for (int i = 0; i < FRAME; i++) begin
      send(W'($urandom), W'($urandom), (i == 0) ? 1'b1 : 1'b0);
      idle(1);
    end
    wait_drain();

    // Randomized traffic: input gaps, per-sample mode noise, random backpressure.
    p0 = pop_cnt;
    fork
      begin
        for (int f = 0; f < 6; f++)
          for (int i = 0; i < FRAME; i++) begin
            idle($urandom_range(0, 2));
            send(W'($urandom), W'($urandom), 1'($urandom));
          end
        in_valid = 1'b0;
        wdone    = 1'b1;
      end
      begin
        while (!wdone) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("rand_count", pop_cnt - p0, 6 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
